// File: rtl/gfx_pkg.sv
// Shared graphics types: line-drawer state encoding and coordinate-width helpers.
// Used by gfx_line_drawer (optional clipping is selected there via GFX_LINE_CLIP_EN).
package gfx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRAW
    } gfx_line_state_t;

    // Bits needed to address 0..extent-1.
    function automatic int coord_bits(input int extent);
        return (extent > 1) ? $clog2(extent) : 1;
    endfunction

    // Signed Bresenham error width: the wider coordinate plus sign and doubling headroom.
    function automatic int err_bits(input int x_bits, input int y_bits);
        return ((x_bits > y_bits) ? x_bits : y_bits) + 2;
    endfunction

endpackage

// File: rtl/gfx_line_drawer.sv
// Bresenham line rasterizer: one command in, one pixel per cycle out on the gfx stream.
// Define GFX_LINE_CLIP_EN to step off-screen pixels silently instead of emitting them.
module gfx_line_drawer
    import gfx_pkg::*;
#(
    parameter int PIXEL_BITS = 12,
    parameter int H_VISIBLE  = 640,
    parameter int V_VISIBLE  = 480,
    localparam int FB_X_BITS = coord_bits(H_VISIBLE),
    localparam int FB_Y_BITS = coord_bits(V_VISIBLE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FB_X_BITS-1:0]  cmd_x0,
    input  logic [FB_Y_BITS-1:0]  cmd_y0,
    input  logic [FB_X_BITS-1:0]  cmd_x1,
    input  logic [FB_Y_BITS-1:0]  cmd_y1,
    input  logic [PIXEL_BITS-1:0] cmd_color,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [FB_X_BITS-1:0]  gfx_x,
    output logic [FB_Y_BITS-1:0]  gfx_y,
    output logic [PIXEL_BITS-1:0] gfx_color,
    output logic                  gfx_valid,
    input  logic                  gfx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int ERR_W = err_bits(FB_X_BITS, FB_Y_BITS);

    gfx_line_state_t         state;
    logic [FB_X_BITS-1:0]    x1;
    logic [FB_Y_BITS-1:0]    y1;
    logic                    sx;
    logic                    sy;
    logic signed [ERR_W-1:0] dx;
    logic signed [ERR_W-1:0] dy;
    logic signed [ERR_W-1:0] err;

    logic signed [ERR_W-1:0] e2;
    logic signed [ERR_W-1:0] err_next;
    logic signed [ERR_W-1:0] dx_setup;
    logic signed [ERR_W-1:0] dy_abs;
    logic [FB_X_BITS-1:0]    nx;
    logic [FB_Y_BITS-1:0]    ny;
    logic                    step_x;
    logic                    step_y;
    logic                    last;
    logic                    advance;
    logic                    next_visible;
    logic                    setup_visible;

    // gfx_x/gfx_y double as the current Bresenham position.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        e2            = err <<< 1;
        step_x        = (e2 >= dy);
        step_y        = (e2 <= dx);
        nx            = gfx_x;
        ny            = gfx_y;
        err_next      = err;
        dx_setup      = (x1 >= gfx_x) ? ERR_W'(x1 - gfx_x) : ERR_W'(gfx_x - x1);
        dy_abs        = (y1 >= gfx_y) ? ERR_W'(y1 - gfx_y) : ERR_W'(gfx_y - y1);
        last          = (gfx_x == x1) && (gfx_y == y1);
        // An invisible (clipped) pixel needs no downstream handshake to advance.
        advance       = (state == DRAW) && (gfx_ready || !gfx_valid);
        if (step_x) begin
            err_next = err_next + dy;
            nx       = sx ? gfx_x + FB_X_BITS'(1) : gfx_x - FB_X_BITS'(1);
        end
        if (step_y) begin
            err_next = err_next + dx;
            ny       = sy ? gfx_y + FB_Y_BITS'(1) : gfx_y - FB_Y_BITS'(1);
        end
`ifdef GFX_LINE_CLIP_EN
        next_visible  = (int'(nx) < H_VISIBLE) && (int'(ny) < V_VISIBLE);
        setup_visible = (int'(gfx_x) < H_VISIBLE) && (int'(gfx_y) < V_VISIBLE);
`else
        next_visible  = 1'b1;
        setup_visible = 1'b1;
`endif
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            gfx_valid <= 1'b0;
            gfx_x     <= '0;
            gfx_y     <= '0;
            gfx_color <= '0;
            x1        <= '0;
            y1        <= '0;
            sx        <= 1'b0;
            sy        <= 1'b0;
            dx        <= '0;
            dy        <= '0;
            err       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        gfx_x     <= cmd_x0;
                        gfx_y     <= cmd_y0;
                        x1        <= cmd_x1;
                        y1        <= cmd_y1;
                        gfx_color <= cmd_color;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    dx        <= dx_setup;
                    dy        <= -dy_abs;
                    err       <= dx_setup - dy_abs;
                    sx        <= (x1 >= gfx_x);
                    sy        <= (y1 >= gfx_y);
                    gfx_valid <= setup_visible;
                    state     <= DRAW;
                end
                DRAW: begin
                    if (advance) begin
                        if (last) begin
                            gfx_valid <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            gfx_x     <= nx;
                            gfx_y     <= ny;
                            err       <= err_next;
                            gfx_valid <= next_visible;
                        end
                    end
                end
                default: begin
                    gfx_valid <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
